rr_req_agent: RTL and testbench

Requester-side agent for one port of the 4-way round-robin grant arbiter. It buffers outgoing words in a small FIFO and drives the arbiter `req` line while words are pending. It emits exactly one word onto the shared resource bus for each cycle its `grant` bit is high. It also tracks grant latency and flags protocol violations, so each client can be checked for fairness in isolation. One instance sits between each client and its `req[i]`/`grant[i]` pair.

---
 rtl/rr_req_agent.sv | 105 ++++++++++
 tb/tb_rr_req_agent.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_agent.sv
// rr_req_agent
//   Requester-side agent for one port of a 4-way round-robin grant arbiter.
//   It buffers client words in a circular FIFO and raises req while words are
//   pending. It places exactly one word on the shared bus per granted cycle.
//   It also records the grant wait history and flags protocol violations.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  client push handshake, in_data = client word
//   req / grant     arbiter request out, arbiter grant in
//   out_valid       a word is on the shared bus this cycle (== a pop)
//   out_data        FIFO head, qualify with out_valid
//   fill            FIFO occupancy, 0..DEPTH
//   spurious        sticky: grant seen while the FIFO was empty
//   starve          sticky: wait run exceeded STARVE_LIM
//   wait_max        longest requesting-without-grant run, saturates at 255
//
// DEPTH must be a power of 2 and at least 2. Pointers wrap by overflow.
module rr_req_agent #(
  parameter int DW         = 8,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     req,
  input  logic                     grant,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     spurious,
  output logic                     starve,
  output logic [7:0]               wait_max
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, empty, full;
  logic [7:0]    wait_cnt;
  logic [8:0]    wait_inc;
  logic [7:0]    wait_sat;

  assign empty     = (fill == '0);
  assign full      = (fill == FW'(DEPTH));
  assign pop       = grant && !empty;
  // A pop on a full FIFO frees its slot in the same cycle.
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;
  assign out_valid = pop;
  assign out_data  = mem[rd_ptr];
  // Count only words that are still present after this cycle's pop, so req
  // drops while the last word goes out. The registered arbiter grant then
  // cannot land on an empty FIFO. A same-cycle push is not counted yet.
  assign req       = (fill - FW'(pop)) != '0;

  // Storage is not reset. out_data stays undefined until the first push.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Wait monitor. wait_inc is one bit wider so the 255 -> 256 step is visible.
  assign wait_inc = {1'b0, wait_cnt} + 9'd1;
  assign wait_sat = wait_inc[8] ? 8'hFF : wait_inc[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      wait_max <= '0;
      starve   <= 1'b0;
      spurious <= 1'b0;
    end else begin
      if (req && !grant) begin
        wait_cnt <= wait_sat;
        if (wait_inc > {1'b0, wait_max}) wait_max <= wait_sat;
        if ({23'd0, wait_inc} > 32'(STARVE_LIM)) starve <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (grant && empty) spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_req_agent.sv
module tb_rr_req_agent;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        iv = '0;
  logic [N-1:0]        ir;
  logic [N-1:0][7:0]   idat = '0;
  logic [N-1:0]        req_v;
  logic [N-1:0]        grant_v;
  logic [N-1:0]        man_gnt = '0;
  logic [N-1:0]        ov;
  logic [N-1:0][7:0]   odat;
  logic [N-1:0][2:0]   fill_v;
  logic [N-1:0]        spur;
  logic [N-1:0]        stv;
  logic [N-1:0][7:0]   wmax;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_ag
    rr_req_agent #(.DW(8), .DEPTH(4), .STARVE_LIM(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .in_data  (idat[g]),
      .req      (req_v[g]),
      .grant    (grant_v[g]),
      .out_valid(ov[g]),
      .out_data (odat[g]),
      .fill     (fill_v[g]),
      .spurious (spur[g]),
      .starve   (stv[g]),
      .wait_max (wmax[g])
    );
  end

  // Reference registered round-robin arbiter: grant in t+1 from req in t.
  logic         arb_en = 1'b0;
  logic [N-1:0] arb_gnt;
  logic [1:0]   arb_last;
  logic [1:0]   arb_idx;
  logic         arb_hit;

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = arb_last;
    for (int k = 1; k <= N; k++) begin
      if (!arb_hit && req_v[(int'(arb_last) + k) % N]) begin
        arb_hit = 1'b1;
        arb_idx = 2'((int'(arb_last) + k) % N);
      end
    end
  end

  always @(posedge clk) begin
    if (!arb_en) begin
      arb_gnt  <= '0;
      arb_last <= 2'd3;
    end else begin
      arb_gnt <= arb_hit ? (4'b0001 << arb_idx) : 4'b0000;
      if (arb_hit) arb_last <= arb_idx;
    end
  end

  assign grant_v = arb_en ? arb_gnt : man_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  int ngrant;
  int cnt [N];

  initial begin
    // Reset with grant and in_valid held: nothing may push or pop.
    rst = 1'b1; iv[0] = 1'b1; idat[0] = 8'h11; man_gnt[0] = 1'b1;
    step(); step();
    chk("rst_fill", 32'(fill_v[0]), 32'd0);
    chk("rst_req", 32'(req_v[0]), 32'd0);
    chk("rst_ov", 32'(ov[0]), 32'd0);
    chk("rst_ir", 32'(ir[0]), 32'd1);
    chk("rst_spur", 32'(spur[0]), 32'd0);
    chk("rst_starve", 32'(stv[0]), 32'd0);
    chk("rst_wmax", 32'(wmax[0]), 32'd0);
    rst = 1'b0; iv[0] = 1'b0; man_gnt[0] = 1'b0;

    // Single word, idle arbiter.
    iv[0] = 1'b1; idat[0] = 8'hA5;
    step();
    iv[0] = 1'b0; #1;
    chk("one_req_c1", 32'(req_v[0]), 32'd1);
    chk("one_fill_c1", 32'(fill_v[0]), 32'd1);
    chk("one_data_c1", 32'(odat[0]), 32'hA5);
    chk("one_ov_c1", 32'(ov[0]), 32'd0);
    step();
    man_gnt[0] = 1'b1; #1;
    chk("one_ov_c2", 32'(ov[0]), 32'd1);
    chk("one_data_c2", 32'(odat[0]), 32'hA5);
    chk("one_req_c2", 32'(req_v[0]), 32'd0);
    step();
    man_gnt[0] = 1'b0; #1;
    chk("one_fill_end", 32'(fill_v[0]), 32'd0);
    chk("one_spur", 32'(spur[0]), 32'd0);
    chk("one_wmax", 32'(wmax[0]), 32'd1);

    // Fill to full, then push and pop every cycle, then drain.
    for (int k = 0; k < 4; k++) begin
      iv[0] = 1'b1; idat[0] = 8'(8'h10 + k);
      step();
    end
    iv[0] = 1'b0; #1;
    chk("full_fill", 32'(fill_v[0]), 32'd4);
    chk("full_ir", 32'(ir[0]), 32'd0);
    chk("full_req", 32'(req_v[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      man_gnt[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'(8'h20 + k); #1;
      chk("pp_ov", 32'(ov[0]), 32'd1);
      chk("pp_data", 32'(odat[0]), 32'(8'h10 + k));
      chk("pp_ir", 32'(ir[0]), 32'd1);
      chk("pp_fill", 32'(fill_v[0]), 32'd4);
      step();
    end
    iv[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_ov", 32'(ov[0]), 32'd1);
      chk("drain_data", 32'(odat[0]), 32'(8'h20 + k));
      chk("drain_fill", 32'(fill_v[0]), 32'(4 - k));
      chk("drain_req", 32'(req_v[0]), (k == 3) ? 32'd0 : 32'd1);
      step();
    end

    // Grant with an empty FIFO.
    #1;
    chk("spur_ov", 32'(ov[0]), 32'd0);
    chk("spur_pre", 32'(spur[0]), 32'd0);
    step();
    chk("spur_set", 32'(spur[0]), 32'd1);
    chk("spur_fill", 32'(fill_v[0]), 32'd0);
    man_gnt[0] = 1'b0;
    step();
    chk("spur_sticky", 32'(spur[0]), 32'd1);
    chk("spur_wmax", 32'(wmax[0]), 32'd3);

    // Starvation: one word waiting with grant tied low.
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("rst2_spur", 32'(spur[0]), 32'd0);
    chk("rst2_wmax", 32'(wmax[0]), 32'd0);
    chk("rst2_fill", 32'(fill_v[0]), 32'd0);
    iv[0] = 1'b1; idat[0] = 8'h5A;
    step();
    iv[0] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("stv_wmax8", 32'(wmax[0]), 32'd8);
    chk("stv_clr8", 32'(stv[0]), 32'd0);
    step();
    chk("stv_wmax9", 32'(wmax[0]), 32'd9);
    chk("stv_set9", 32'(stv[0]), 32'd1);
    man_gnt[0] = 1'b1; #1;
    chk("stv_ov", 32'(ov[0]), 32'd1);
    chk("stv_data", 32'(odat[0]), 32'h5A);
    step();
    man_gnt[0] = 1'b0;
    step();
    chk("stv_sticky", 32'(stv[0]), 32'd1);
    chk("stv_fill", 32'(fill_v[0]), 32'd0);

    // Four agents sharing the reference arbiter, staggered 3-word bursts.
    rst = 1'b1; step(); rst = 1'b0; arb_en = 1'b1;
    ngrant = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < N; i++) begin
        iv[i]   = (c >= i) && (c < i + 3);
        idat[i] = 8'(i * 16 + (c - i));
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (ov[i]) begin
          chk("rr_port", 32'(i), 32'(ngrant % N));
          chk("rr_data", 32'(odat[i]), 32'(i * 16 + cnt[i]));
          cnt[i]++;
          ngrant++;
        end
      end
      step();
    end
    iv = '0; arb_en = 1'b0;
    chk("rr_total", 32'(ngrant), 32'd12);
    for (int i = 0; i < N; i++) begin
      chk("rr_cnt", 32'(cnt[i]), 32'd3);
      chk("rr_wmax_le3", 32'(wmax[i] <= 8'd3), 32'd1);
      chk("rr_starve", 32'(stv[i]), 32'd0);
      chk("rr_spur", 32'(spur[i]), 32'd0);
      chk("rr_fill", 32'(fill_v[i]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
